// File: rtl/wc_pkg.sv
// Shared types and constants for the window/cursor command controller.
package wc_pkg;

  typedef enum logic [2:0] {
    CMD_UP    = 3'd0,
    CMD_DOWN  = 3'd1,
    CMD_LEFT  = 3'd2,
    CMD_RIGHT = 3'd3,
    CMD_ZIN   = 3'd4,
    CMD_ZOUT  = 3'd5,
    CMD_MODE  = 3'd6
  } cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_HOLD    = 2'd2,
    ST_RELEASE = 2'd3
  } state_e;

  typedef struct packed {
    logic move_mode;
    logic zoom_out;
    logic zoom_in;
    logic move_right;
    logic move_left;
    logic move_down;
    logic move_up;
  } wc_cmds_t;

  localparam int         CNT_W        = 26;
  localparam logic [2:0] WC_MIN_LOG2  = 3'd2;
  localparam logic [2:0] WC_MAX_LOG2  = 3'd7;
  localparam logic [2:0] WC_INIT_LOG2 = 3'd3;

  function automatic cmd_e lowest_cmd(input logic [6:0] req);
    cmd_e sel;
    sel = CMD_UP;
    for (int i = 6; i >= 0; i--) begin
      if (req[i]) sel = cmd_e'(3'(i));
    end
    return sel;
  endfunction

  function automatic logic is_move(input cmd_e c);
    return c inside {CMD_UP, CMD_DOWN, CMD_LEFT, CMD_RIGHT};
  endfunction

  function automatic logic is_zoom(input cmd_e c);
    return c inside {CMD_ZIN, CMD_ZOUT};
  endfunction

endpackage

// File: rtl/wc_repeat_timer.sv
// Auto-repeat down-counter: loads a period, decrements while enabled and
// flags the cycle in which the count reaches zero.
module wc_repeat_timer
  import wc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             expire_o
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Expires on the decrement that lands on zero, so the repeat period is exact.
  assign expire_o = dec_i && (cnt_q <= CNT_W'(1));

endmodule

// File: rtl/wc_cmd_ctrl.sv
// Window/cursor command sequencer: arbitrates buttons and keyboard into one
// pulse per cycle. Define WC_CMD_CTRL_STATS_EN to add drop/grant counters.
module wc_cmd_ctrl
  import wc_pkg::*;
#(
  parameter logic [CNT_W-1:0] REPEAT_DLY = 26'd25_000_000,
  parameter logic [CNT_W-1:0] REPEAT_PER = 26'd5_000_000,
  parameter logic [2:0]       MIN_LOG2   = WC_MIN_LOG2,
  parameter logic [2:0]       MAX_LOG2   = WC_MAX_LOG2,
  parameter logic [2:0]       INIT_LOG2  = WC_INIT_LOG2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       run_mode,
  input  logic [6:0] btn_req,
  input  logic       kbd_valid,
  input  logic [2:0] kbd_cmd,
  output wc_cmds_t   wc_cmds,
  output logic [7:0] win_numCells,
  output logic [2:0] zoom_lvl,
  output logic       busy
`ifdef WC_CMD_CTRL_STATS_EN
  ,
  output logic [7:0]  drop_cnt,
  output logic [15:0] grant_cnt
`endif
);

  state_e     state_q, state_d;
  cmd_e       cmd_sel_q, cmd_sel_d;
  cmd_e       pend_cmd_q, pend_cmd_d;
  logic       pend_vld_q, pend_vld_d;
  logic       first_q, first_d;
  logic [5:0] pulse_q, pulse_d;
  logic       mode_q, mode_d;
  logic [2:0] zoom_q, zoom_d;

  logic       zoom_pulse_on;
  logic       kbd_grant;
  logic       fsm_grant;
  logic       gnt;
  cmd_e       gnt_cmd;
  logic       clamp;
  logic       kbd_drop;
  logic       timer_load;
  logic       timer_dec;
  logic       timer_expire;

  // A zoom on the output has not yet updated zoom_q, so zoom grants wait a cycle.
  assign zoom_pulse_on = pulse_q[CMD_ZIN] | pulse_q[CMD_ZOUT];
  assign kbd_grant     = pend_vld_q && !(is_zoom(pend_cmd_q) && zoom_pulse_on);
  assign fsm_grant     = (state_q == ST_ISSUE) && !pend_vld_q &&
                         !(is_zoom(cmd_sel_q) && zoom_pulse_on);
  assign gnt           = kbd_grant | fsm_grant;
  assign gnt_cmd       = kbd_grant ? pend_cmd_q : cmd_sel_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (btn_req != 7'd0) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (fsm_grant) state_d = is_move(cmd_sel_q) ? ST_HOLD : ST_RELEASE;
      end
      ST_HOLD: begin
        if (!btn_req[cmd_sel_q]) state_d = ST_RELEASE;
        else if (timer_expire)   state_d = ST_ISSUE;
      end
      ST_RELEASE: begin
        if (btn_req == 7'd0) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    pulse_d = '0;
    mode_d  = mode_q;
    clamp   = 1'b0;
    zoom_d  = zoom_q;
    if (pulse_q[CMD_ZIN]) begin
      zoom_d = zoom_q - 3'd1;
    end else if (pulse_q[CMD_ZOUT]) begin
      zoom_d = zoom_q + 3'd1;
    end
    if (gnt) begin
      case (gnt_cmd)
        CMD_UP:    pulse_d[CMD_UP]    = 1'b1;
        CMD_DOWN:  pulse_d[CMD_DOWN]  = 1'b1;
        CMD_LEFT:  pulse_d[CMD_LEFT]  = 1'b1;
        CMD_RIGHT: pulse_d[CMD_RIGHT] = 1'b1;
        CMD_ZIN: begin
          if (zoom_q == MIN_LOG2) clamp = 1'b1;
          else                    pulse_d[CMD_ZIN] = 1'b1;
        end
        CMD_ZOUT: begin
          if (zoom_q == MAX_LOG2) clamp = 1'b1;
          else                    pulse_d[CMD_ZOUT] = 1'b1;
        end
        CMD_MODE: begin
          if (!run_mode) mode_d = ~mode_q;
        end
        default: ;
      endcase
    end

    pend_vld_d = pend_vld_q & ~kbd_grant;
    pend_cmd_d = pend_cmd_q;
    kbd_drop   = 1'b0;
    if (kbd_valid && kbd_cmd != 3'd7) begin
      if (pend_vld_q) begin
        kbd_drop = 1'b1;
      end else begin
        pend_vld_d = 1'b1;
        pend_cmd_d = cmd_e'(kbd_cmd);
      end
    end

    cmd_sel_d = cmd_sel_q;
    first_d   = first_q;
    if (state_q == ST_IDLE && btn_req != 7'd0) begin
      cmd_sel_d = lowest_cmd(btn_req);
      first_d   = 1'b1;
    end else if (fsm_grant) begin
      first_d = 1'b0;
    end

    timer_load = fsm_grant && is_move(cmd_sel_q);
    timer_dec  = (state_q == ST_HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_sel_q  <= CMD_UP;
      pend_cmd_q <= CMD_UP;
      pend_vld_q <= 1'b0;
      first_q    <= 1'b0;
      pulse_q    <= '0;
      mode_q     <= 1'b0;
      zoom_q     <= INIT_LOG2;
    end else begin
      cmd_sel_q  <= cmd_sel_d;
      pend_cmd_q <= pend_cmd_d;
      pend_vld_q <= pend_vld_d;
      first_q    <= first_d;
      pulse_q    <= pulse_d;
      mode_q     <= mode_d;
      zoom_q     <= zoom_d;
    end
  end

  wc_repeat_timer u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (timer_load),
    .load_val_i (first_q ? REPEAT_DLY : REPEAT_PER),
    .dec_i      (timer_dec),
    .expire_o   (timer_expire)
  );

  assign wc_cmds      = wc_cmds_t'({run_mode | mode_q, pulse_q});
  assign win_numCells = 8'd1 << zoom_q;
  assign zoom_lvl     = zoom_q;
  assign busy         = (state_q != ST_IDLE) || pend_vld_q;

`ifdef WC_CMD_CTRL_STATS_EN
  logic [7:0]  drop_q;
  logic [15:0] grant_q;
  logic [8:0]  drop_sum;

  assign drop_sum = 9'(drop_q) + 9'(kbd_drop) + 9'(clamp);

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q  <= '0;
      grant_q <= '0;
    end else begin
      drop_q  <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
      grant_q <= grant_q + 16'(|pulse_d);
    end
  end

  assign drop_cnt  = drop_q;
  assign grant_cnt = grant_q;
`else
  logic stats_unused;
  assign stats_unused = kbd_drop ^ clamp;
`endif

endmodule

// File: tb/tb_wc_cmd_ctrl.sv
// Directed bench for wc_cmd_ctrl: expected pulses (cycle, size, command)
// are queued as stimulus is driven and matched when they appear.
module tb_wc_cmd_ctrl;
  import wc_pkg::*;

  logic       clk;
  logic       rst;
  logic       run_mode;
  logic [6:0] btn_req;
  logic       kbd_valid;
  logic [2:0] kbd_cmd;
  wc_cmds_t   wc_cmds;
  logic [7:0] win_numCells;
  logic [2:0] zoom_lvl;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int t0;
  logic [31:0] exp_q[$];

  wc_cmd_ctrl #(
    .REPEAT_DLY (26'd10),
    .REPEAT_PER (26'd4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .run_mode     (run_mode),
    .btn_req      (btn_req),
    .kbd_valid    (kbd_valid),
    .kbd_cmd      (kbd_cmd),
    .wc_cmds      (wc_cmds),
    .win_numCells (win_numCells),
    .zoom_lvl     (zoom_lvl),
    .busy         (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ent(input int c, input logic [7:0] w, input logic [2:0] idx);
    logic [31:0] cv;
    cv = 32'(c);
    return {cv[15:0], w, 5'd0, idx};
  endfunction

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_kbd(input logic [2:0] c, input logic exp_pulse, input logic [7:0] w);
    t0 = cyc;
    kbd_valid = 1'b1;
    kbd_cmd   = c;
    if (exp_pulse) exp_q.push_back(ent(t0 + 2, w, c));
    tick();
    kbd_valid = 1'b0;
    repeat (3) tick();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cmds"}, 32'(wc_cmds), 32'd0);
    check({tag, "_zoom"}, 32'(zoom_lvl), 32'd3);
    check({tag, "_win"},  32'(win_numCells), 32'd8);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // scoreboard: every visible pulse must match the head of exp_q
  always @(negedge clk) begin : monitor
    logic [5:0] p;
    logic [2:0] idx;
    p = {wc_cmds.zoom_out, wc_cmds.zoom_in, wc_cmds.move_right,
         wc_cmds.move_left, wc_cmds.move_down, wc_cmds.move_up};
    if ((|p) === 1'b1) begin
      check("pulse_onehot", 32'($countones(p)), 32'd1);
      idx = 3'd0;
      for (int i = 5; i >= 0; i--) if (p[i]) idx = 3'(i);
      if (exp_q.size() == 0) begin
        check("unexpected_pulse", ent(cyc, win_numCells, idx), 32'd0);
      end else begin
        check("pulse", ent(cyc, win_numCells, idx), exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; run_mode = 1'b0; btn_req = 7'd0; kbd_valid = 1'b0; kbd_cmd = 3'd0;
    repeat (3) tick();
    rst = 1'b0;

    // 1: idle after reset
    repeat (10) tick();
    check_reset_outputs("reset");
    check("reset_mode", 32'(wc_cmds.move_mode), 32'd0);

    // 2: held move with auto-repeat
    t0 = cyc;
    btn_req = 7'b0000001;
    exp_q.push_back(ent(t0 + 2,  8'd8, 3'd0));
    exp_q.push_back(ent(t0 + 13, 8'd8, 3'd0));
    exp_q.push_back(ent(t0 + 18, 8'd8, 3'd0));
    exp_q.push_back(ent(t0 + 23, 8'd8, 3'd0));
    exp_q.push_back(ent(t0 + 28, 8'd8, 3'd0));
    repeat (5) tick();
    check("hold_busy", 32'(busy), 32'd1);
    repeat (25) tick();
    btn_req = 7'd0;
    repeat (20) tick();
    check("repeat_drained", 32'(exp_q.size()), 32'd0);
    check("release_busy", 32'(busy), 32'd0);

    // 3: keyboard wins over a button rising in the same cycle
    t0 = cyc;
    kbd_valid = 1'b1; kbd_cmd = 3'd3; btn_req = 7'b0000010;
    exp_q.push_back(ent(t0 + 2, 8'd8, 3'd3));
    exp_q.push_back(ent(t0 + 3, 8'd8, 3'd1));
    tick();
    kbd_valid = 1'b0;
    repeat (3) tick();
    btn_req = 7'd0;
    repeat (5) tick();
    check("arb_drained", 32'(exp_q.size()), 32'd0);

    // 4: zoom clamping, size visible during pulse is the old one
    send_kbd(3'd4, 1'b1, 8'd8);
    check("zoom_to_min", 32'(zoom_lvl), 32'd2);
    check("win_at_min", 32'(win_numCells), 32'd4);
    send_kbd(3'd4, 1'b0, 8'd0);
    check("zoom_in_clamped", 32'(zoom_lvl), 32'd2);
    for (int i = 0; i < 6; i++) send_kbd(3'd5, i < 5, 8'd4 << i);
    check("zoom_at_max", 32'(zoom_lvl), 32'd7);
    check("win_at_max", 32'(win_numCells), 32'd128);
    check("zoom_drained", 32'(exp_q.size()), 32'd0);

    // 4b: keyboard zoom waits out a button zoom pulse
    t0 = cyc;
    btn_req = 7'b0010000;
    exp_q.push_back(ent(t0 + 2, 8'd128, 3'd4));
    exp_q.push_back(ent(t0 + 4, 8'd64,  3'd4));
    tick();
    btn_req = 7'd0; kbd_valid = 1'b1; kbd_cmd = 3'd4;
    tick();
    kbd_valid = 1'b0;
    repeat (4) tick();
    check("stall_zoom", 32'(zoom_lvl), 32'd5);
    check("stall_drained", 32'(exp_q.size()), 32'd0);

    // 5: move_mode toggle and run_mode override
    check("mode_init", 32'(wc_cmds.move_mode), 32'd0);
    send_kbd(3'd6, 1'b0, 8'd0);
    check("mode_toggled", 32'(wc_cmds.move_mode), 32'd1);
    run_mode = 1'b1;
    tick();
    check("mode_run_forced", 32'(wc_cmds.move_mode), 32'd1);
    send_kbd(3'd6, 1'b0, 8'd0);
    check("mode_run_ignored", 32'(wc_cmds.move_mode), 32'd1);
    run_mode = 1'b0;
    tick();
    check("mode_preserved", 32'(wc_cmds.move_mode), 32'd1);

    // 6a: reset during HOLD
    t0 = cyc;
    btn_req = 7'b0000001;
    exp_q.push_back(ent(t0 + 2, 8'd32, 3'd0));
    repeat (6) tick();
    check("hold6_busy", 32'(busy), 32'd1);
    rst = 1'b1; btn_req = 7'd0;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_hold");
    check("rst_hold_mode", 32'(wc_cmds.move_mode), 32'd0);

    // 6b: reset in the grant cycle aborts the pending pulse
    kbd_valid = 1'b1; kbd_cmd = 3'd4;
    tick();
    kbd_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_grant");
    repeat (3) tick();

    // 6c: reset during a zoom pulse cycle keeps the reset zoom level
    t0 = cyc;
    kbd_valid = 1'b1; kbd_cmd = 3'd4;
    exp_q.push_back(ent(t0 + 2, 8'd8, 3'd4));
    tick();
    kbd_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_reset_outputs("rst_zoom");

    repeat (5) tick();
    check("final_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
